// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker
//
// Sequential response checker for small 4-input / 2-output combinational
// blocks. On an accepted start it walks pat through 0..15 ({x,y,w,z}, x is
// the MSB), holds each index for SETTLE+1 cycles and samples the device's
// (s, t) response on the last edge of that window. Each sample is compared
// against the GOLDEN_S / GOLDEN_T truth tables. The checker reports the
// number of failing indices, the lowest failing index and a pass flag.
//
// Parameters:
//   GOLDEN_S  expected s, bit i is the value for input index i
//   GOLDEN_T  expected t, bit i is the value for input index i
//   SETTLE    extra hold cycles per index before sampling (0..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (level, accepted only while busy=0)
//   pat        stimulus to the device under test {x,y,w,z}
//   resp_s     device output s
//   resp_t     device output t
//   busy       sweep in progress
//   done       one-cycle pulse when a sweep completes
//   pass       last completed sweep had zero mismatches
//   err_cnt    failing indices in the current or last sweep (0..16)
//   first_err  lowest failing index, valid when err_valid=1
//   err_valid  at least one mismatch in the current or last sweep
//
// Every output comes straight from a flop; resp_s/resp_t and start only
// reach outputs through the registers below.
// ---------------------------------------------------------------------------
module tt_sweep_checker #(
  parameter logic [15:0] GOLDEN_S = 16'h7F00,
  parameter logic [15:0] GOLDEN_T = 16'h7F00,
  parameter int unsigned SETTLE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] pat,
  input  logic       resp_s,
  input  logic       resp_t,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] first_err,
  output logic       err_valid
);

  // Hold counter only needs to count up to 15.
  localparam logic [3:0] SETTLE_V = SETTLE[3:0];

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  state_e     state_q;
  logic [3:0] pat_q;
  logic [3:0] hold_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_cnt_q;
  logic [3:0] first_err_q;
  logic       err_valid_q;

  logic       sample_now;
  logic       mismatch;
  logic [4:0] err_cnt_d;

  // Sampling happens on the last edge of the hold window for the current
  // index. err_cnt_d is the count including this sample, which is what the
  // final pass decision at index 15 must see.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    sample_now = 1'b0;
    mismatch   = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (state_q == SWEEP && hold_q == SETTLE_V) begin
      sample_now = 1'b1;
      // An index counts once even when both s and t are wrong.
      mismatch   = (resp_s != GOLDEN_S[pat_q]) || (resp_t != GOLDEN_T[pat_q]);
      err_cnt_d  = err_cnt_q + {4'd0, mismatch};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pat_q       <= 4'd0;
      hold_q      <= 4'd0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= 5'd0;
      first_err_q <= 4'd0;
      err_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Results hold here until the next accepted start clears them.
          if (start) begin
            state_q     <= SWEEP;
            pat_q       <= 4'd0;
            hold_q      <= 4'd0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 5'd0;
            first_err_q <= 4'd0;
            err_valid_q <= 1'b0;
          end
        end
        SWEEP: begin
          // start is deliberately ignored while sweeping.
          if (sample_now) begin
            err_cnt_q <= err_cnt_d;
            if (mismatch && !err_valid_q) begin
              first_err_q <= pat_q;
              err_valid_q <= 1'b1;
            end
            hold_q <= 4'd0;
            if (pat_q == 4'd15) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              pat_q   <= 4'd0;
              pass_q  <= (err_cnt_d == 5'd0);
            end else begin
              pat_q <= pat_q + 4'd1;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pat       = pat_q;
  assign busy      = (state_q == SWEEP);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign err_valid = err_valid_q;

endmodule

// File: doc/tt_sweep_checker.md
# tt_sweep_checker

Sequential response checker for small 4-input/2-output combinational blocks. It drives the exhaustive 4-bit input sweep (index 0..15, x as MSB, z as LSB) into a device under test and samples the DUT's two outputs (s, t) at each index. Each sample is compared against a golden truth table and the checker reports a mismatch count, the first failing index and a pass flag. It sits on the consumer side of the combinational function blocks, replacing hand-read `$monitor` tables with a self-checking sweep usable in simulation and on an FPGA harness.

## Interface
Parameters:
- GOLDEN_S, default 16'h7F00: expected s; bit i is the value for input index i.
- GOLDEN_T, default 16'h7F00: expected t; bit i is the value for input index i.
- SETTLE, default 1: extra cycles each pattern is held before sampling. Legal range 0..15.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a sweep. Level sampled; accepted only when busy=0.
- pat  output  4  DUT stimulus {x,y,w,z}.
- resp_s  input  1  DUT output s.
- resp_t  input  1  DUT output t.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  last completed sweep had zero mismatches.
- err_cnt  output  5  mismatching indices in the current or last sweep (0..16).
- first_err  output  4  lowest failing index. Meaningful only when err_valid=1.
- err_valid  output  1  at least one mismatch seen in the current or last sweep.

## Operation
- States are IDLE and SWEEP. DONE is not a separate state; it is a registered pulse emitted on the SWEEP->IDLE transition.
- IDLE to SWEEP happens when start=1 on a clock edge. The same edge loads:
  - pat=0, hold counter=0;
  - err_cnt=0, err_valid=0, first_err=0, pass=0.
- In SWEEP, each index i is held on pat for SETTLE+1 cycles. The DUT response is sampled on the last edge of that hold window.
- A sample is a mismatch if resp_s != GOLDEN_S[i] or resp_t != GOLDEN_T[i]. An index counts once even if both bits are wrong.
- On a mismatch:
  - err_cnt increments;
  - if err_valid=0, set first_err=i and err_valid=1.
- After index i<15 is sampled, pat becomes i+1 and the hold counter resets.
- After index 15 is sampled, the FSM returns to IDLE with:
  - busy=0, done=1 for one cycle, pat=0;
  - pass=1 iff final err_cnt==0, where the final count includes the index-15 sample.
- start while busy=1 is ignored and the sweep continues unaffected.
- start=1 in the cycle done=1 is legal (busy=0 then). It begins a new sweep and clears the results on that edge.
- In IDLE, results hold their values until the next accepted start.
- err_cnt cannot exceed 16, so no saturation logic is needed.
- Reset mid-sweep aborts immediately, with no done pulse and no partial result retained.

## Timing
- Reset values: pat=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0, err_valid=0, FSM in IDLE.
- Let start be accepted at edge k. Then:
  - busy and pat=0 are visible after edge k;
  - index i is sampled at edge k+(i+1)(SETTLE+1);
  - the done pulse and final results are visible after edge k+16(SETTLE+1).
- Sweep length is 16(SETTLE+1) cycles: 32 with the default, 16 with SETTLE=0.
- With SETTLE=0 the DUT has one cycle from a pat change to its sample. The DUT path must be combinational and meet timing within that cycle.
- err_cnt, first_err and err_valid update on the sampling edge and are observable mid-sweep.
- All outputs are registered. There is no combinational path from resp_s/resp_t or start to any output.

## Test plan
- Good DUT (s=t=x&~(y&w&z)) with defaults, start pulsed once -> done after 32 cycles, pass=1, err_cnt=0, err_valid=0, pat walks 0..15 and returns to 0.
- DUT forced to s=1 only when pat=5 -> err_cnt=1, first_err=5, err_valid=1, pass=0.
- DUT outputs inverted at every index -> err_cnt=16, first_err=0, pass=0.
- SETTLE=0 with a good DUT -> done exactly 16 cycles after start is accepted; start held high on the done cycle -> second sweep begins with results cleared and passes again.
- start re-pulsed at index 7 -> ignored, done still at the original cycle. Then rst_n asserted at index 9 of a new sweep -> all outputs return to reset values immediately and no done pulse occurs.
